// File: rtl/ex_mem_pipeline_register_pkg.sv
// Shared types and constants for the EX/MEM pipeline register and its memory wait-state sequencer.
package ex_mem_pipeline_register_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

    localparam int unsigned DEF_REG_ADDR_BITS = 5;
    localparam int unsigned MEM_LATENCY_MAX   = 15;
    localparam int unsigned CNT_W             = 4;
    localparam int unsigned STAT_W            = 32;

    // Control bundle carried from execute to memory/writeback.
    typedef struct packed {
        logic mem_write;
        logic mem_read;
        logic reg_write;
        logic mem_to_reg;
        logic branch_eq;
        logic branch_ne;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/ex_mem_pipeline_register_mem_wait_sequencer.sv
// Holds a captured load/store in the EX/MEM stage for MEM_LATENCY cycles; busy while extra cycles remain.
module mem_wait_sequencer
    import ex_mem_pipeline_register_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic flush_i,
    output logic busy_o
);

    localparam int unsigned LAT = (MEM_LATENCY > MEM_LATENCY_MAX) ? MEM_LATENCY_MAX : MEM_LATENCY;

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Count keeps running under downstream stall so the memory op always completes.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && (LAT > 1)) begin
                        state_d = ST_ACCESS;
                        count_d = CNT_W'(LAT - 1);
                    end
                end
                ST_ACCESS: begin
                    count_d = count_q - CNT_W'(1);
                    if (count_q <= CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    assign busy_o = (state_q == ST_ACCESS);

endmodule

// File: rtl/ex_mem_pipeline_register.sv
// EX/MEM boundary register with valid, stall/flush and memory wait states.
// Define EX_MEM_STATS_EN to add saturating StallCycles/BubbleCycles counters.
module ex_mem_pipeline_register
    import ex_mem_pipeline_register_pkg::*;
#(
    parameter int unsigned NBits       = 32,
    parameter int unsigned RegAddrBits = DEF_REG_ADDR_BITS,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall_in,
    input  logic                   flush_in,
    input  logic                   in_valid,
    input  logic                   MemWrite_in,
    input  logic                   MemRead_in,
    input  logic                   RegWrite_in,
    input  logic                   MemtoReg_in,
    input  logic                   BranchEquals_in,
    input  logic                   BranchNotEquals_in,
    input  logic                   Zero_in,
    input  logic [RegAddrBits-1:0] WriteRegister_in,
    input  logic [NBits-1:0]       ALUResult_in,
    input  logic [NBits-1:0]       ReadData2_in,
    input  logic [NBits-1:0]       PC_4_in,
    input  logic [NBits-1:0]       BranchAddress_in,
    output logic                   out_valid,
    output logic                   MemWrite,
    output logic                   MemRead,
    output logic                   RegWrite,
    output logic                   MemtoReg,
    output logic                   BranchEquals,
    output logic                   BranchNotEquals,
    output logic                   Zero,
    output logic [RegAddrBits-1:0] WriteRegister,
    output logic [NBits-1:0]       ALUResult,
    output logic [NBits-1:0]       ReadData2,
    output logic [NBits-1:0]       PC_4,
    output logic [NBits-1:0]       BranchAddress,
`ifdef EX_MEM_STATS_EN
    output logic [STAT_W-1:0]      StallCycles,
    output logic [STAT_W-1:0]      BubbleCycles,
`endif
    output logic                   stall_out
);

    logic busy;
    logic hold;
    logic capture;
    logic start;
    ctrl_t ctrl_in;

    logic                   valid_q, valid_d;
    ctrl_t                  ctrl_q, ctrl_d;
    logic                   zero_q, zero_d;
    logic [RegAddrBits-1:0] wreg_q, wreg_d;
    logic [NBits-1:0]       alu_q, alu_d;
    logic [NBits-1:0]       rd2_q, rd2_d;
    logic [NBits-1:0]       pc4_q, pc4_d;
    logic [NBits-1:0]       baddr_q, baddr_d;

    assign ctrl_in = '{mem_write:  MemWrite_in,
                       mem_read:   MemRead_in,
                       reg_write:  RegWrite_in,
                       mem_to_reg: MemtoReg_in,
                       branch_eq:  BranchEquals_in,
                       branch_ne:  BranchNotEquals_in};

    assign hold    = stall_in | busy;
    assign capture = ~flush_in & ~hold;
    assign start   = capture & in_valid & (MemRead_in | MemWrite_in);

    mem_wait_sequencer #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_mem_wait_sequencer (
        .clk     (clk),
        .rst_n   (reset),
        .start_i (start),
        .flush_i (flush_in),
        .busy_o  (busy)
    );

    // Data registers keep their contents on flush; only the valid bit is killed.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        zero_d  = zero_q;
        wreg_d  = wreg_q;
        alu_d   = alu_q;
        rd2_d   = rd2_q;
        pc4_d   = pc4_q;
        baddr_d = baddr_q;
        if (capture) begin
            valid_d = in_valid;
            ctrl_d  = ctrl_in;
            zero_d  = Zero_in;
            wreg_d  = WriteRegister_in;
            alu_d   = ALUResult_in;
            rd2_d   = ReadData2_in;
            pc4_d   = PC_4_in;
            baddr_d = BranchAddress_in;
        end
        if (flush_in) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            zero_q  <= 1'b0;
            wreg_q  <= '0;
            alu_q   <= '0;
            rd2_q   <= '0;
            pc4_q   <= '0;
            baddr_q <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            zero_q  <= zero_d;
            wreg_q  <= wreg_d;
            alu_q   <= alu_d;
            rd2_q   <= rd2_d;
            pc4_q   <= pc4_d;
            baddr_q <= baddr_d;
        end
    end

    // A bubble must never write memory/registers or redirect fetch.
    assign out_valid       = valid_q;
    assign MemWrite        = ctrl_q.mem_write  & valid_q;
    assign MemRead         = ctrl_q.mem_read   & valid_q;
    assign RegWrite        = ctrl_q.reg_write  & valid_q;
    assign MemtoReg        = ctrl_q.mem_to_reg & valid_q;
    assign BranchEquals    = ctrl_q.branch_eq  & valid_q;
    assign BranchNotEquals = ctrl_q.branch_ne  & valid_q;
    assign Zero            = zero_q;
    assign WriteRegister   = wreg_q;
    assign ALUResult       = alu_q;
    assign ReadData2       = rd2_q;
    assign PC_4            = pc4_q;
    assign BranchAddress   = baddr_q;
    assign stall_out       = busy | stall_in;

`ifdef EX_MEM_STATS_EN
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [STAT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall_out && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STAT_W'(1);
        end
        if (!valid_q && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign StallCycles  = stall_cnt_q;
    assign BubbleCycles = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_pipeline_register.sv
// Self-checking bench for ex_mem_pipeline_register: directed cases plus randomized traffic vs. a behavioural model.
module tb_ex_mem_pipeline_register;

    localparam int unsigned NB  = 32;
    localparam int unsigned RB  = 5;
    localparam int unsigned LAT = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall_in, flush_in, in_valid;
    logic          MemWrite_in, MemRead_in, RegWrite_in, MemtoReg_in;
    logic          BranchEquals_in, BranchNotEquals_in, Zero_in;
    logic [RB-1:0] WriteRegister_in;
    logic [NB-1:0] ALUResult_in, ReadData2_in, PC_4_in, BranchAddress_in;

    logic          out_valid, MemWrite, MemRead, RegWrite, MemtoReg;
    logic          BranchEquals, BranchNotEquals, Zero, stall_out;
    logic [RB-1:0] WriteRegister;
    logic [NB-1:0] ALUResult, ReadData2, PC_4, BranchAddress;
`ifdef EX_MEM_STATS_EN
    logic [31:0]   StallCycles, BubbleCycles;
`endif

    ex_mem_pipeline_register #(
        .NBits       (NB),
        .RegAddrBits (RB),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk                (clk),
        .reset              (rst_n),
        .stall_in           (stall_in),
        .flush_in           (flush_in),
        .in_valid           (in_valid),
        .MemWrite_in        (MemWrite_in),
        .MemRead_in         (MemRead_in),
        .RegWrite_in        (RegWrite_in),
        .MemtoReg_in        (MemtoReg_in),
        .BranchEquals_in    (BranchEquals_in),
        .BranchNotEquals_in (BranchNotEquals_in),
        .Zero_in            (Zero_in),
        .WriteRegister_in   (WriteRegister_in),
        .ALUResult_in       (ALUResult_in),
        .ReadData2_in       (ReadData2_in),
        .PC_4_in            (PC_4_in),
        .BranchAddress_in   (BranchAddress_in),
        .out_valid          (out_valid),
        .MemWrite           (MemWrite),
        .MemRead            (MemRead),
        .RegWrite           (RegWrite),
        .MemtoReg           (MemtoReg),
        .BranchEquals       (BranchEquals),
        .BranchNotEquals    (BranchNotEquals),
        .Zero               (Zero),
        .WriteRegister      (WriteRegister),
        .ALUResult          (ALUResult),
        .ReadData2          (ReadData2),
        .PC_4               (PC_4),
        .BranchAddress      (BranchAddress),
`ifdef EX_MEM_STATS_EN
        .StallCycles        (StallCycles),
        .BubbleCycles       (BubbleCycles),
`endif
        .stall_out          (stall_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Model: one entry plus the number of extra cycles the entry is still pinned by a memory op.
    logic          m_valid = 1'b0;
    int            m_remain = 0;
    logic          m_mw = 1'b0, m_mr = 1'b0, m_rw = 1'b0, m_m2r = 1'b0, m_beq = 1'b0, m_bne = 1'b0;
    logic          m_zero = 1'b0;
    logic [RB-1:0] m_wreg = '0;
    logic [NB-1:0] m_alu = '0, m_rd2 = '0, m_pc4 = '0, m_ba = '0;
    int            m_stall_cnt = 0, m_bub_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_remain = 0;
            m_mw = 1'b0; m_mr = 1'b0; m_rw = 1'b0; m_m2r = 1'b0; m_beq = 1'b0; m_bne = 1'b0;
            m_zero = 1'b0; m_wreg = '0; m_alu = '0; m_rd2 = '0; m_pc4 = '0; m_ba = '0;
            m_stall_cnt = 0; m_bub_cnt = 0;
        end else begin
            if ((m_remain > 0) || stall_in) m_stall_cnt++;
            if (!m_valid) m_bub_cnt++;
            if (flush_in) begin
                m_valid  = 1'b0;
                m_remain = 0;
            end else if (m_remain > 0) begin
                m_remain--;
            end else if (!stall_in) begin
                m_valid = in_valid;
                m_mw = MemWrite_in; m_mr = MemRead_in; m_rw = RegWrite_in; m_m2r = MemtoReg_in;
                m_beq = BranchEquals_in; m_bne = BranchNotEquals_in; m_zero = Zero_in;
                m_wreg = WriteRegister_in; m_alu = ALUResult_in; m_rd2 = ReadData2_in;
                m_pc4 = PC_4_in; m_ba = BranchAddress_in;
                m_remain = (in_valid && (MemRead_in || MemWrite_in)) ? int'(LAT) - 1 : 0;
            end
        end
    end

    // Every-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid",       32'(out_valid),       32'(m_valid));
            chk("MemWrite",        32'(MemWrite),        32'(m_mw  & m_valid));
            chk("MemRead",         32'(MemRead),         32'(m_mr  & m_valid));
            chk("RegWrite",        32'(RegWrite),        32'(m_rw  & m_valid));
            chk("MemtoReg",        32'(MemtoReg),        32'(m_m2r & m_valid));
            chk("BranchEquals",    32'(BranchEquals),    32'(m_beq & m_valid));
            chk("BranchNotEquals", 32'(BranchNotEquals), 32'(m_bne & m_valid));
            chk("stall_out",       32'(stall_out),       32'((m_remain > 0) || stall_in));
            if (m_valid) begin
                chk("Zero",          32'(Zero),          32'(m_zero));
                chk("WriteRegister", 32'(WriteRegister), 32'(m_wreg));
                chk("ALUResult",     ALUResult,          m_alu);
                chk("ReadData2",     ReadData2,          m_rd2);
                chk("PC_4",          PC_4,               m_pc4);
                chk("BranchAddress", BranchAddress,      m_ba);
            end
`ifdef EX_MEM_STATS_EN
            chk("StallCycles",  StallCycles,  32'(m_stall_cnt));
            chk("BubbleCycles", BubbleCycles, 32'(m_bub_cnt));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        stall_in = 1'b0; flush_in = 1'b0; in_valid = 1'b0;
        MemWrite_in = 1'b0; MemRead_in = 1'b0; RegWrite_in = 1'b0; MemtoReg_in = 1'b0;
        BranchEquals_in = 1'b0; BranchNotEquals_in = 1'b0; Zero_in = 1'b0;
        WriteRegister_in = '0; ALUResult_in = '0; ReadData2_in = '0; PC_4_in = '0; BranchAddress_in = '0;
    endtask

    task automatic drive_random();
        stall_in           = ($urandom_range(0, 3) == 0);
        flush_in           = ($urandom_range(0, 15) == 0);
        in_valid           = ($urandom_range(0, 3) != 0);
        MemWrite_in        = ($urandom_range(0, 3) == 0);
        MemRead_in         = ($urandom_range(0, 3) == 0);
        RegWrite_in        = 1'($urandom);
        MemtoReg_in        = 1'($urandom);
        BranchEquals_in    = 1'($urandom);
        BranchNotEquals_in = 1'($urandom);
        Zero_in            = 1'($urandom);
        WriteRegister_in   = RB'($urandom);
        ALUResult_in       = $urandom;
        ReadData2_in       = $urandom;
        PC_4_in            = $urandom;
        BranchAddress_in   = $urandom;
    endtask

    initial begin
        drive_idle();
        step();
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst ALUResult", ALUResult,      32'h0);
        chk("rst stall_out", 32'(stall_out), 32'h0);
        chk("rst MemRead",   32'(MemRead),   32'h0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Plain ALU op: one-cycle latency.
        in_valid = 1'b1; RegWrite_in = 1'b1; ALUResult_in = 32'h0000_0010;
        step();
        chk("alu out_valid", 32'(out_valid), 32'h1);
        chk("alu ALUResult", ALUResult,      32'h0000_0010);
        chk("alu RegWrite",  32'(RegWrite),  32'h1);
        chk("alu stall_out", 32'(stall_out), 32'h0);

        // Load held for three cycles; next op waits.
        MemRead_in = 1'b1; MemtoReg_in = 1'b1; ALUResult_in = 32'h1001_0004;
        step();
        MemRead_in = 1'b0; MemtoReg_in = 1'b0; ALUResult_in = 32'h0000_0022;
        chk("ld1 MemRead",   32'(MemRead),   32'h1);
        chk("ld1 stall_out", 32'(stall_out), 32'h1);
        chk("ld1 ALUResult", ALUResult,      32'h1001_0004);
        step();
        chk("ld2 MemRead",   32'(MemRead),   32'h1);
        chk("ld2 stall_out", 32'(stall_out), 32'h1);
        step();
        chk("ld3 MemRead",   32'(MemRead),   32'h1);
        chk("ld3 ALUResult", ALUResult,      32'h1001_0004);
        chk("ld3 stall_out", 32'(stall_out), 32'h0);
        step();
        chk("ld4 ALUResult", ALUResult,      32'h0000_0022);
        chk("ld4 MemRead",   32'(MemRead),   32'h0);

        // Store flushed while in its wait states.
        RegWrite_in = 1'b0; MemWrite_in = 1'b1; ALUResult_in = 32'h0000_0044;
        step();
        chk("st MemWrite",  32'(MemWrite),  32'h1);
        chk("st stall_out", 32'(stall_out), 32'h1);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        chk("stf out_valid", 32'(out_valid), 32'h0);
        chk("stf MemWrite",  32'(MemWrite),  32'h0);
        chk("stf stall_out", 32'(stall_out), 32'h0);

        // Downstream stall freezes outputs; flush with stall kills the entry.
        MemWrite_in = 1'b0; RegWrite_in = 1'b1; ALUResult_in = 32'h0000_0055;
        step();
        chk("stl0 ALUResult", ALUResult, 32'h0000_0055);
        stall_in = 1'b1; ALUResult_in = 32'h0000_0066;
        step();
        chk("stl1 ALUResult", ALUResult,      32'h0000_0055);
        chk("stl1 out_valid", 32'(out_valid), 32'h1);
        chk("stl1 stall_out", 32'(stall_out), 32'h1);
        ALUResult_in = 32'h0000_0077;
        step();
        chk("stl2 ALUResult", ALUResult, 32'h0000_0055);
        flush_in = 1'b1;
        step();
        chk("stlf out_valid", 32'(out_valid), 32'h0);
        chk("stlf RegWrite",  32'(RegWrite),  32'h0);
        drive_idle();

        // Branch carried by a bubble must not be seen as taken.
        BranchEquals_in = 1'b1; Zero_in = 1'b1; BranchAddress_in = 32'h0040_0020;
        step();
        chk("br BranchEquals",  32'(BranchEquals), 32'h0);
        chk("br out_valid",     32'(out_valid),    32'h0);
        chk("br Zero",          32'(Zero),         32'h1);
        chk("br BranchAddress", BranchAddress,     32'h0040_0020);
        drive_idle();

        // Async reset in the middle of a memory access.
        in_valid = 1'b1; MemRead_in = 1'b1; ALUResult_in = 32'h0000_0088;
        step();
        chk("rsa stall_out", 32'(stall_out), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rsa2 stall_out", 32'(stall_out), 32'h0);
        chk("rsa2 out_valid", 32'(out_valid), 32'h0);
        chk("rsa2 MemRead",   32'(MemRead),   32'h0);
        drive_idle();
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 2000; i++) begin
            drive_random();
            step();
        end
        drive_idle();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
